// File: rtl/lock_pkg.sv
// Shared types and widths for the combination-lock controller.
package lock_pkg;
  typedef enum logic [1:0] {ENTRY, CHECK, OPEN, DENIED} lock_state_t;
  localparam int ATTEMPT_W   = 2;
  localparam int DIGIT_CNT_W = 4;
endpackage

// File: rtl/btn_edge.sv
// Registered rising-edge pulse for a debounced button level.
// A button held through reset stays disarmed until it has been seen low.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);
  logic prev, armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev  <= 1'b0;
      armed <= 1'b0;
      pulse <= 1'b0;
    end else begin
      prev  <= btn;
      armed <= armed | ~btn;
      pulse <= btn & ~prev & armed;
    end
  end
endmodule

// File: rtl/combo_lock_ctrl.sv
// Combination-lock controller: digit entry, registered compare, attempt count, lockout.
// Optional macro LOCK_TIMEOUT_EN makes the DENIED lockout expire after LOCKOUT_CYCLES clocks.
module combo_lock_ctrl
  import lock_pkg::*;
#(
  parameter int                          NUM_DIGITS     = 4,
  parameter int                          DIGIT_W        = 4,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] CODE         = 16'h1234,
  parameter int                          MAX_ATTEMPTS   = 3,
  parameter logic [31:0]                 LOCKOUT_CYCLES = 32'd50_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIGIT_W-1:0] sw,
  input  logic               enter,
  input  logic               clear,
  input  logic               relock,
  output logic               done,
  output logic               fail,
  output logic [1:0]         attempt,
  output logic [3:0]         digit_cnt
);
  localparam int                     CODE_W  = NUM_DIGITS * DIGIT_W;
  localparam logic [ATTEMPT_W-1:0]   MAX_ATT = ATTEMPT_W'(MAX_ATTEMPTS);
  localparam logic [DIGIT_CNT_W-1:0] NDIG    = DIGIT_CNT_W'(NUM_DIGITS);

  generate
    if (MAX_ATTEMPTS < 1 || MAX_ATTEMPTS > 3)
      $error("combo_lock_ctrl: MAX_ATTEMPTS must be 1..3");
    if (NUM_DIGITS < 2 || NUM_DIGITS > 8)
      $error("combo_lock_ctrl: NUM_DIGITS must be 2..8");
    if (LOCKOUT_CYCLES < 32'd1)
      $error("combo_lock_ctrl: LOCKOUT_CYCLES must be nonzero");
  endgenerate

  logic enter_p, relock_p;

  btn_edge u_enter_edge  (.clk(clk), .rst(rst), .btn(enter),  .pulse(enter_p));
  btn_edge u_relock_edge (.clk(clk), .rst(rst), .btn(relock), .pulse(relock_p));

  lock_state_t       state;
  logic [CODE_W-1:0] entry;
`ifdef LOCK_TIMEOUT_EN
  logic [31:0]       lock_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ENTRY;
      done      <= 1'b0;
      fail      <= 1'b0;
      attempt   <= MAX_ATT;
      digit_cnt <= '0;
      entry     <= '0;
`ifdef LOCK_TIMEOUT_EN
      lock_cnt  <= '0;
`endif
    end else begin
      case (state)
        ENTRY: begin
          // clear takes priority over a same-cycle digit
          if (clear) begin
            digit_cnt <= '0;
            entry     <= '0;
          end else if (enter_p) begin
            entry     <= {entry[CODE_W-DIGIT_W-1:0], sw};
            digit_cnt <= digit_cnt + 1'b1;
            if (digit_cnt + 1'b1 == NDIG) state <= CHECK;
          end
        end
        CHECK: begin
          digit_cnt <= '0;
          entry     <= '0;
          if (entry == CODE) begin
            state   <= OPEN;
            done    <= 1'b1;
            attempt <= MAX_ATT;
          end else if (attempt > 2'd1) begin
            state   <= ENTRY;
            attempt <= attempt - 1'b1;
          end else begin
            state   <= DENIED;
            fail    <= 1'b1;
`ifdef LOCK_TIMEOUT_EN
            lock_cnt <= '0;
`endif
          end
        end
        OPEN: begin
          if (relock_p) begin
            state <= ENTRY;
            done  <= 1'b0;
          end
        end
        DENIED: begin
`ifdef LOCK_TIMEOUT_EN
          if (lock_cnt == LOCKOUT_CYCLES - 32'd1) begin
            state    <= ENTRY;
            fail     <= 1'b0;
            attempt  <= MAX_ATT;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + 32'd1;
          end
`else
          state <= DENIED;
`endif
        end
        default: state <= ENTRY;
      endcase
    end
  end
endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Directed bench for combo_lock_ctrl (code 1234, 3 attempts, lockout 20 cycles).
module tb_combo_lock_ctrl;
  logic       clk = 1'b0;
  logic       rst, enter, clear, relock;
  logic [3:0] sw;
  logic       done, fail;
  logic [1:0] attempt;
  logic [3:0] digit_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  combo_lock_ctrl #(
    .NUM_DIGITS(4), .DIGIT_W(4), .CODE(16'h1234),
    .MAX_ATTEMPTS(3), .LOCKOUT_CYCLES(32'd20)
  ) dut (
    .clk(clk), .rst(rst), .sw(sw), .enter(enter), .clear(clear), .relock(relock),
    .done(done), .fail(fail), .attempt(attempt), .digit_cnt(digit_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // one-cycle press; returns at the negedge just after the sampling edge
  task automatic press(input logic [3:0] d);
    @(negedge clk); sw = d; enter = 1'b1;
    @(negedge clk); enter = 1'b0;
  endtask

  task automatic press_relock();
    @(negedge clk); relock = 1'b1;
    @(negedge clk); relock = 1'b0;
  endtask

  task automatic code(input logic [15:0] c);
    press(c[15:12]); press(c[11:8]); press(c[7:4]); press(c[3:0]);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".done"},    32'(done),      32'd0);
    chk({tag, ".fail"},    32'(fail),      32'd0);
    chk({tag, ".attempt"}, 32'(attempt),   32'd3);
    chk({tag, ".cnt"},     32'(digit_cnt), 32'd0);
  endtask

  initial begin
    rst = 1'b1; enter = 1'b1; clear = 1'b0; relock = 1'b0; sw = 4'h1;
    idle(3);
    chk_reset("reset");
    // enter held through reset must not count
    rst = 1'b0;
    idle(5);
    chk("held_thru_rst", 32'(digit_cnt), 32'd0);
    enter = 1'b0;
    idle(2);

    // correct code with exact latency
    press(4'h1); press(4'h2); press(4'h3);
    idle(2);
    chk("cnt3", 32'(digit_cnt), 32'd3);
    press(4'h4);
    chk("lat0.done", 32'(done), 32'd0);
    idle(1);
    chk("lat1.done", 32'(done), 32'd0);
    chk("check.cnt", 32'(digit_cnt), 32'd4);
    idle(1);
    chk("lat2.done", 32'(done), 32'd1);
    chk("open.fail", 32'(fail), 32'd0);
    chk("open.attempt", 32'(attempt), 32'd3);
    chk("open.cnt", 32'(digit_cnt), 32'd0);
    press(4'h1);
    @(negedge clk); clear = 1'b1; @(negedge clk); clear = 1'b0;
    idle(3);
    chk("open.ignore_enter", 32'(digit_cnt), 32'd0);
    chk("open.hold", 32'(done), 32'd1);
    press_relock();
    idle(3);
    chk("relock.done", 32'(done), 32'd0);
    press(4'h1); idle(2);
    chk("relock.entry", 32'(digit_cnt), 32'd1);
    @(negedge clk); clear = 1'b1; @(negedge clk); clear = 1'b0;

    // wrong code then right code
    code(16'h1235); idle(1);
    chk("wrong.lat1", 32'(attempt), 32'd3);
    idle(1);
    chk("wrong.attempt", 32'(attempt), 32'd2);
    chk("wrong.done", 32'(done), 32'd0);
    chk("wrong.fail", 32'(fail), 32'd0);
    chk("wrong.cnt", 32'(digit_cnt), 32'd0);
    code(16'h1234); idle(3);
    chk("retry.done", 32'(done), 32'd1);
    chk("retry.attempt", 32'(attempt), 32'd3);
    press_relock(); idle(3);

    // lockout: first digit wrong counts too
    code(16'h0234); idle(3);
    chk("lock.a2", 32'(attempt), 32'd2);
    code(16'h1235); idle(3);
    chk("lock.a1", 32'(attempt), 32'd1);
    chk("lock.a1.fail", 32'(fail), 32'd0);
    code(16'h4321); idle(1);
    chk("lock.lat1", 32'(fail), 32'd0);
    idle(1);
    chk("lock.fail", 32'(fail), 32'd1);
    chk("lock.attempt", 32'(attempt), 32'd1);
    chk("lock.done", 32'(done), 32'd0);
`ifdef LOCK_TIMEOUT_EN
    idle(19);
    chk("timeout.pre", 32'(fail), 32'd1);
    idle(1);
    chk("timeout.fail", 32'(fail), 32'd0);
    chk("timeout.attempt", 32'(attempt), 32'd3);
    code(16'h4321); code(16'h4321); code(16'h4321); idle(3);
    chk("relock2.fail", 32'(fail), 32'd1);
`else
    press(4'h1); press_relock();
    @(negedge clk); clear = 1'b1; @(negedge clk); clear = 1'b0;
    code(16'h1234);
    idle(30);
    chk("denied.sticky", 32'(fail), 32'd1);
    chk("denied.cnt", 32'(digit_cnt), 32'd0);
    chk("denied.done", 32'(done), 32'd0);
`endif
    // reset in DENIED
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
    chk_reset("rst_denied");
    idle(2);

    // held enter counts once
    @(negedge clk); sw = 4'h1; enter = 1'b1;
    idle(100);
    chk("held.cnt", 32'(digit_cnt), 32'd1);
    enter = 1'b0;
    press(4'h2); idle(2);
    chk("held.cnt2", 32'(digit_cnt), 32'd2);

    // clear alone, then clear coinciding with the enter pulse
    @(negedge clk); clear = 1'b1; @(negedge clk); clear = 1'b0;
    idle(1);
    chk("clear.cnt", 32'(digit_cnt), 32'd0);
    chk("clear.attempt", 32'(attempt), 32'd3);
    @(negedge clk); sw = 4'h1; enter = 1'b1;
    @(negedge clk); enter = 1'b0; clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    idle(2);
    chk("clear_enter.cnt", 32'(digit_cnt), 32'd0);

    // reset after 3 digits, then a full correct code
    press(4'h1); press(4'h2); press(4'h3); idle(2);
    chk("mid.cnt3", 32'(digit_cnt), 32'd3);
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
    chk_reset("rst_mid");
    idle(2);
    code(16'h1234); idle(3);
    chk("post_rst.done", 32'(done), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
